// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath word, ALU opcodes and the ALU arbiter FSM/grant types.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  aluop_t;

    localparam aluop_t ALU_SLL  = 4'd0;
    localparam aluop_t ALU_SRL  = 4'd1;
    localparam aluop_t ALU_ADD  = 4'd2;
    localparam aluop_t ALU_SUB  = 4'd3;
    localparam aluop_t ALU_AND  = 4'd4;
    localparam aluop_t ALU_OR   = 4'd5;
    localparam aluop_t ALU_XOR  = 4'd6;
    localparam aluop_t ALU_NOR  = 4'd7;
    localparam aluop_t ALU_SLT  = 4'd8;
    localparam aluop_t ALU_SLTU = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef logic arb_id_t;

endpackage

// File: rtl/alu_if.sv
// Connection bundle between an ALU and whoever drives it.
interface alu_if;
    import cpu_types_pkg::*;

    word_t  portA;
    word_t  portB;
    aluop_t aluop;
    word_t  outport;
    logic   negative;
    logic   zero;
    logic   overflow;

    modport alu (input portA, portB, aluop, output outport, negative, zero, overflow);
    modport drv (output portA, portB, aluop, input outport, negative, zero, overflow);

endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU; shifts move portA by portB[4:0].
module alu
    import cpu_types_pkg::*;
(
    alu_if.alu aluif
);

    word_t sum;
    word_t diff;
    word_t res;
    logic  ovf;

    assign sum  = aluif.portA + aluif.portB;
    assign diff = aluif.portA - aluif.portB;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (aluif.aluop)
            ALU_SLL:  res = aluif.portA << aluif.portB[4:0];
            ALU_SRL:  res = aluif.portA >> aluif.portB[4:0];
            ALU_ADD: begin
                res = sum;
                ovf = (aluif.portA[31] == aluif.portB[31]) && (sum[31] != aluif.portA[31]);
            end
            ALU_SUB: begin
                res = diff;
                ovf = (aluif.portA[31] != aluif.portB[31]) && (diff[31] != aluif.portA[31]);
            end
            ALU_AND:  res = aluif.portA & aluif.portB;
            ALU_OR:   res = aluif.portA | aluif.portB;
            ALU_XOR:  res = aluif.portA ^ aluif.portB;
            ALU_NOR:  res = ~(aluif.portA | aluif.portB);
            ALU_SLT:  res = {31'b0, $signed(aluif.portA) < $signed(aluif.portB)};
            ALU_SLTU: res = {31'b0, aluif.portA < aluif.portB};
            // Unassigned opcodes yield zero with clear overflow.
            default:  res = '0;
        endcase
    end

    assign aluif.outport  = res;
    assign aluif.negative = res[31];
    assign aluif.zero     = (res == '0);
    assign aluif.overflow = ovf;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared ALU: IDLE -> EXEC -> RESP with a one-cycle ack.
// Define ALU_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module alu_arbiter
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  word_t      portA0,
    input  word_t      portB0,
    input  aluop_t     aluop0,
    input  word_t      portA1,
    input  word_t      portB1,
    input  aluop_t     aluop1,
    output logic [1:0] ack,
    output word_t      result,
    output logic       negative,
    output logic       zero,
    output logic       overflow,
    output logic       busy
);

    arb_state_t state_q;
    word_t      opA_r;
    word_t      opB_r;
    aluop_t     op_r;
    arb_id_t    gnt_r;
    arb_id_t    win;

    alu_if aluif ();
    alu u_alu (.aluif(aluif));

    assign aluif.portA = opA_r;
    assign aluif.portB = opB_r;
    assign aluif.aluop = op_r;

`ifdef ALU_ARB_RR_EN
    arb_id_t last;

    always_comb begin
        win = (req == 2'b11) ? ~last : req[1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            last <= 1'b1;
        else if (state_q == IDLE && req != 2'b00)
            last <= win;
    end
`else
    // Requester 0 wins whenever it is asking.
    always_comb begin
        win = ~req[0];
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ack      <= 2'b00;
            busy     <= 1'b0;
            result   <= '0;
            negative <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            opA_r    <= '0;
            opB_r    <= '0;
            op_r     <= '0;
            gnt_r    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        opA_r   <= win ? portA1 : portA0;
                        opB_r   <= win ? portB1 : portB0;
                        op_r    <= win ? aluop1 : aluop0;
                        gnt_r   <= win;
                        busy    <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    result   <= aluif.outport;
                    negative <= aluif.negative;
                    zero     <= aluif.zero;
                    overflow <= aluif.overflow;
                    ack      <= gnt_r ? 2'b10 : 2'b01;
                    state_q  <= RESP;
                end
                RESP: begin
                    ack     <= 2'b00;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack     <= 2'b00;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus tie, stability and reset sequences.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] req;
    word_t      portA0, portB0, portA1, portB1;
    aluop_t     aluop0, aluop1;
    logic [1:0] ack;
    word_t      result;
    logic       negative, zero, overflow, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] req;
        word_t      a0, b0;
        aluop_t     op0;
        word_t      a1, b1;
        aluop_t     op1;
        logic [1:0] ack;
        word_t      res;
        logic       n, z, v;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK = ~CLK;

    alu_arbiter dut (
        .CLK(CLK), .RST(RST), .req(req),
        .portA0(portA0), .portB0(portB0), .aluop0(aluop0),
        .portA1(portA1), .portB1(portB1), .aluop1(aluop1),
        .ack(ack), .result(result),
        .negative(negative), .zero(zero), .overflow(overflow), .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // The idle requester gets decoy operands so a wrong mux select is visible.
    task automatic add(input logic [1:0] r, input word_t a, input word_t b, input aluop_t op,
                       input word_t res, input logic n, input logic z, input logic v);
        vec_t t;
        t.req = r;
        t.ack = r;
        t.res = res;
        t.n = n; t.z = z; t.v = v;
        if (r == 2'b01) begin
            t.a0 = a; t.b0 = b; t.op0 = op;
            t.a1 = ~a; t.b1 = b + 3; t.op1 = ALU_SUB;
        end else begin
            t.a1 = a; t.b1 = b; t.op1 = op;
            t.a0 = ~a; t.b0 = b + 3; t.op0 = ALU_SUB;
        end
        vecs.push_back(t);
    endtask

    task automatic do_txn(input vec_t t, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge CLK);
        portA0 = t.a0; portB0 = t.b0; aluop0 = t.op0;
        portA1 = t.a1; portB1 = t.b1; aluop1 = t.op1;
        req = t.req;
        @(posedge CLK);
        @(negedge CLK);
        req = 2'b00;
        chk({nm, "_exec_ack"}, 64'(ack), 64'(2'b00));
        chk({nm, "_exec_busy"}, 64'(busy), 64'(1'b1));
        @(posedge CLK);
        @(negedge CLK);
        chk({nm, "_ack"}, 64'(ack), 64'(t.ack));
        chk({nm, "_result"}, 64'(result), 64'(t.res));
        chk({nm, "_flags"}, 64'({negative, zero, overflow}), 64'({t.n, t.z, t.v}));
        chk({nm, "_resp_busy"}, 64'(busy), 64'(1'b1));
        @(posedge CLK);
        @(negedge CLK);
        chk({nm, "_idle_ack"}, 64'(ack), 64'(2'b00));
        chk({nm, "_idle_busy"}, 64'(busy), 64'(1'b0));
    endtask

    initial begin
        logic [1:0] got_ack[$];
        word_t      got_res[$];
        logic [1:0] exp_ack[3];
        word_t      exp_res[3];
        int         stray;

        add(2'b01, 32'd5,        32'd7,        ALU_ADD,  32'd12,       1'b0, 1'b0, 1'b0);
        add(2'b10, 32'h7FFFFFFF, 32'd1,        ALU_ADD,  32'h80000000, 1'b1, 1'b0, 1'b1);
        add(2'b01, 32'd5,        32'd5,        ALU_SUB,  32'd0,        1'b0, 1'b1, 1'b0);
        add(2'b10, 32'd0,        32'd1,        ALU_SUB,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        add(2'b01, 32'h80000000, 32'd1,        ALU_SUB,  32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
        add(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, ALU_ADD,  32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        add(2'b01, 32'h0000F0F0, 32'h0000FF00, ALU_AND,  32'h0000F000, 1'b0, 1'b0, 1'b0);
        add(2'b10, 32'h0000F0F0, 32'h0000FF00, ALU_OR,   32'h0000FFF0, 1'b0, 1'b0, 1'b0);
        add(2'b01, 32'hFFFFFFFF, 32'h0F0F0F0F, ALU_XOR,  32'hF0F0F0F0, 1'b1, 1'b0, 1'b0);
        add(2'b10, 32'd0,        32'd0,        ALU_NOR,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        add(2'b01, 32'hFFFFFFFF, 32'd1,        ALU_SLT,  32'd1,        1'b0, 1'b0, 1'b0);
        add(2'b10, 32'hFFFFFFFF, 32'd1,        ALU_SLTU, 32'd0,        1'b0, 1'b1, 1'b0);
        add(2'b01, 32'd1,        32'd4,        ALU_SLL,  32'd16,       1'b0, 1'b0, 1'b0);
        add(2'b10, 32'h80000000, 32'd31,       ALU_SRL,  32'd1,        1'b0, 1'b0, 1'b0);
        add(2'b01, 32'h1234,     32'h5678,     4'hF,     32'd0,        1'b0, 1'b1, 1'b0);

        // Reset held with both requests pending.
        RST = 1'b1;
        req = 2'b11;
        portA0 = 32'd1;  portB0 = 32'd1;  aluop0 = ALU_ADD;
        portA1 = 32'd10; portB1 = 32'd10; aluop1 = ALU_ADD;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_ack", 64'(ack), 64'(2'b00));
            chk("rst_busy", 64'(busy), 64'(1'b0));
            chk("rst_result", 64'(result), 64'(0));
            chk("rst_flags", 64'({negative, zero, overflow}), 64'(3'b000));
        end

        // Tie held for nine cycles straight out of reset.
        RST = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (ack != 2'b00) begin
                got_ack.push_back(ack);
                got_res.push_back(result);
            end
        end
        req = 2'b00;
`ifdef ALU_ARB_RR_EN
        exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01;
        exp_res[0] = 32'd2; exp_res[1] = 32'd20; exp_res[2] = 32'd2;
`else
        exp_ack[0] = 2'b01; exp_ack[1] = 2'b01; exp_ack[2] = 2'b01;
        exp_res[0] = 32'd2; exp_res[1] = 32'd2; exp_res[2] = 32'd2;
`endif
        chk("tie_ack_count", 64'(got_ack.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < got_ack.size()) begin
                chk($sformatf("tie_ack%0d", i), 64'(got_ack[i]), 64'(exp_ack[i]));
                chk($sformatf("tie_res%0d", i), 64'(got_res[i]), 64'(exp_res[i]));
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        chk("tie_drain_busy", 64'(busy), 64'(1'b0));

        foreach (vecs[i]) do_txn(vecs[i], i);

        // Operands and opcode change while the latched copy executes.
        @(negedge CLK);
        portA0 = 32'd3; portB0 = 32'd4; aluop0 = ALU_ADD;
        req = 2'b01;
        @(posedge CLK);
        @(negedge CLK);
        req = 2'b00;
        portA0 = 32'd100; aluop0 = ALU_SUB;
        @(posedge CLK);
        @(negedge CLK);
        chk("stab_ack", 64'(ack), 64'(2'b01));
        chk("stab_result", 64'(result), 64'(7));
        @(posedge CLK);

        // Reset lands in EXEC: operation is dropped without an ack.
        @(negedge CLK);
        portA0 = 32'd9; portB0 = 32'd9; aluop0 = ALU_ADD;
        req = 2'b01;
        @(posedge CLK);
        @(negedge CLK);
        req = 2'b00;
        chk("abort_exec_busy", 64'(busy), 64'(1'b1));
        RST = 1'b1;
        #1;
        chk("abort_ack", 64'(ack), 64'(2'b00));
        chk("abort_busy", 64'(busy), 64'(1'b0));
        chk("abort_result", 64'(result), 64'(0));
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (ack != 2'b00 || busy) stray++;
        end
        chk("abort_no_ack", 64'(stray), 64'(0));
        chk("abort_result_hold", 64'(result), 64'(0));
        do_txn(vecs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
